// File: rtl/csa_reduction_pipe.sv
// csa_reduction_pipe: pipelined 3:2 carry-save reduction of NUM_OPS operands to a sum/carry pair
// Ports: clk_i, rst_i (async, active-high); in_valid_i/in_ready_o/in_ops_i/in_tag_i accept an
// operand set; out_valid_o/out_ready_i/out_sum_o/out_carry_o/out_tag_o return the redundant result.
// Macro CSA_FINAL_ADD_EN adds a final register stage that also drives out_total_o = sum + carry.
module csa_reduction_pipe #(
    parameter int NUM_OPS     = 12,
    parameter int WIDTH       = 48,
    parameter int LVL_PER_REG = 1,
    parameter int TAG_W       = 4,
    localparam int OUT_W      = WIDTH + $clog2(NUM_OPS)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [NUM_OPS*WIDTH-1:0] in_ops_i,
    input  logic [TAG_W-1:0]         in_tag_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [OUT_W-1:0]         out_sum_o,
    output logic [OUT_W-1:0]         out_carry_o,
    output logic [TAG_W-1:0]         out_tag_o
`ifdef CSA_FINAL_ADD_EN
    ,
    output logic [OUT_W-1:0]         out_total_o
`endif
);
    // Row count after j compressor levels.
    function automatic int cnt_at(input int j);
        int n = NUM_OPS;
        for (int k = 0; k < j; k++) n = n - n / 3;
        return n;
    endfunction

    function automatic int nlvl();
        int n = NUM_OPS;
        int c = 0;
        while (n > 2) begin
            n = n - n / 3;
            c++;
        end
        return c;
    endfunction

    localparam int NLVL = nlvl();
    localparam int L    = 1 + (NLVL + LVL_PER_REG - 1) / LVL_PER_REG;
`ifdef CSA_FINAL_ADD_EN
    localparam int S    = L + 1;
`else
    localparam int S    = L;
`endif

    logic [S-1:0]     v_q;
    logic [S-1:0]     en;
    logic [TAG_W-1:0] t_q [S];

    // Each stage may load when empty or when the stage after it is moving.
    always_comb begin
        en        = '0;
        en[S-1]   = !v_q[S-1] || out_ready_i;
        for (int k = S - 2; k >= 0; k--) en[k] = !v_q[k] || en[k+1];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            v_q <= '0;
            for (int k = 0; k < S; k++) t_q[k] <= '0;
        end else begin
            if (en[0]) begin
                v_q[0] <= in_valid_i;
                t_q[0] <= in_tag_i;
            end
            for (int k = 1; k < S; k++) begin
                if (en[k]) begin
                    v_q[k] <= v_q[k-1];
                    t_q[k] <= t_q[k-1];
                end
            end
        end
    end

    // Level j: x is the combinational row set, y what the next level sees
    // (registered at stage boundaries, stage index K).
    for (genvar j = 0; j <= NLVL; j++) begin : lv
        localparam int N = cnt_at(j);
        localparam int K = (j + LVL_PER_REG - 1) / LVL_PER_REG;
        logic [N*OUT_W-1:0] x;
        logic [N*OUT_W-1:0] y;
        if (j == 0) begin : ld
            for (genvar i = 0; i < NUM_OPS; i++) begin : z
                assign x[i*OUT_W +: OUT_W] = OUT_W'(in_ops_i[i*WIDTH +: WIDTH]);
            end
        end else begin : cp
            localparam int P = cnt_at(j - 1);
            localparam int G = P / 3;
            for (genvar i = 0; i < G; i++) begin : fa
                logic [OUT_W-1:0] a, b, c;
                assign a = lv[j-1].y[(3*i)*OUT_W +: OUT_W];
                assign b = lv[j-1].y[(3*i+1)*OUT_W +: OUT_W];
                assign c = lv[j-1].y[(3*i+2)*OUT_W +: OUT_W];
                assign x[(2*i)*OUT_W +: OUT_W]   = a ^ b ^ c;
                assign x[(2*i+1)*OUT_W +: OUT_W] = ((a & b) | (a & c) | (b & c)) << 1;
            end
            for (genvar i = 0; i < P - 3 * G; i++) begin : pt
                assign x[(2*G+i)*OUT_W +: OUT_W] = lv[j-1].y[(3*G+i)*OUT_W +: OUT_W];
            end
        end
        if (j % LVL_PER_REG == 0 || j == NLVL) begin : rg
            logic [N*OUT_W-1:0] y_q;
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) y_q <= '0;
                else if (en[K]) y_q <= x;
            end
            assign y = y_q;
        end else begin : cb
            assign y = x;
        end
    end

    logic [OUT_W-1:0] sum_w, car_w;
    assign sum_w = lv[NLVL].y[0 +: OUT_W];
    assign car_w = lv[NLVL].y[OUT_W +: OUT_W];

`ifdef CSA_FINAL_ADD_EN
    logic [OUT_W-1:0] fs_q, fc_q, ft_q;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fs_q <= '0;
            fc_q <= '0;
            ft_q <= '0;
        end else if (en[L]) begin
            fs_q <= sum_w;
            fc_q <= car_w;
            ft_q <= sum_w + car_w;
        end
    end
    assign out_sum_o   = fs_q;
    assign out_carry_o = fc_q;
    assign out_total_o = ft_q;
`else
    assign out_sum_o   = sum_w;
    assign out_carry_o = car_w;
`endif

    assign out_valid_o = v_q[S-1];
    assign out_tag_o   = t_q[S-1];
    assign in_ready_o  = en[0];
endmodule

// File: tb/tb_csa_reduction_pipe.sv
// tb_csa_reduction_pipe: directed self-checking bench for csa_reduction_pipe
module tb_csa_reduction_pipe;
    localparam int N  = 12;
    localparam int W  = 48;
    localparam int OW = 52;
    localparam int TW = 4;
`ifdef CSA_FINAL_ADD_EN
    localparam int LAT  = 6;
    localparam int LAT2 = 2;
`else
    localparam int LAT  = 5;
    localparam int LAT2 = 1;
`endif
    localparam int FULL = LAT + 1;

    logic          clk = 0;
    logic          rst = 1;
    logic          in_valid, in_ready, out_valid, out_ready;
    logic [N*W-1:0] in_ops;
    logic [TW-1:0] in_tag, out_tag;
    logic [OW-1:0] out_sum, out_carry, res;
    logic          in_valid2, in_ready2, out_valid2;
    logic [23:0]   in_ops2;
    logic [TW-1:0] out_tag2;
    logic [9:0]    out_sum2, out_carry2, res2;
`ifdef CSA_FINAL_ADD_EN
    logic [OW-1:0] out_total;
    logic [9:0]    out_total2;
`endif

    always #5 clk = ~clk;

    csa_reduction_pipe dut (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_ops_i(in_ops), .in_tag_i(in_tag), .out_valid_o(out_valid),
        .out_ready_i(out_ready), .out_sum_o(out_sum), .out_carry_o(out_carry),
        .out_tag_o(out_tag)
`ifdef CSA_FINAL_ADD_EN
        , .out_total_o(out_total)
`endif
    );

    csa_reduction_pipe #(.NUM_OPS(3), .WIDTH(8), .LVL_PER_REG(2), .TAG_W(TW)) dut2 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid2), .in_ready_o(in_ready2),
        .in_ops_i(in_ops2), .in_tag_i(4'd0), .out_valid_o(out_valid2),
        .out_ready_i(1'b1), .out_sum_o(out_sum2), .out_carry_o(out_carry2),
        .out_tag_o(out_tag2)
`ifdef CSA_FINAL_ADD_EN
        , .out_total_o(out_total2)
`endif
    );

    assign res  = out_sum + out_carry;
    assign res2 = out_sum2 + out_carry2;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    typedef struct {
        logic [N*W-1:0] ops;
        logic [TW-1:0]  tag;
        logic [OW-1:0]  exp;
    } vec_t;
    vec_t tv[7];

    logic [OW-1:0] q_sum[$];
    logic [TW-1:0] q_tag[$];
    int            q_cyc[$];
    int            cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            q_sum.push_back(res);
            q_tag.push_back(out_tag);
            q_cyc.push_back(cyc);
        end
    end

    function automatic logic [N*W-1:0] all_ops(input logic [W-1:0] v);
        logic [N*W-1:0] r;
        for (int i = 0; i < N; i++) r[i*W +: W] = v;
        return r;
    endfunction

    task automatic qclear();
        q_sum.delete();
        q_tag.delete();
        q_cyc.delete();
    endtask

    // Called #1 after a rising edge; sends one set and checks its single result.
    task automatic run_vec(input logic [N*W-1:0] ops, input logic [TW-1:0] tag,
                           input logic [OW-1:0] exp, input string nm);
        int n;
        in_ops   = ops;
        in_tag   = tag;
        in_valid = 1;
        @(negedge clk);
        chk({nm, "_in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk);
        #1 in_valid = 0;
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1 n++;
        end
        chk({nm, "_latency"}, 64'(n), 64'(LAT));
        chk({nm, "_sum"}, 64'(res), 64'(exp));
        chk({nm, "_tag"}, 64'(out_tag), 64'(tag));
        chk({nm, "_carry_b0"}, 64'(out_carry[0]), 64'd0);
`ifdef CSA_FINAL_ADD_EN
        chk({nm, "_total"}, 64'(out_total), 64'(exp));
`endif
        @(posedge clk);
        #1 chk({nm, "_single"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, a, n;
        logic [OW-1:0] s7;
        in_valid  = 0;
        in_ops    = '0;
        in_tag    = '0;
        out_ready = 1;
        in_valid2 = 0;
        in_ops2   = '0;
        for (int j = 0; j < 7; j++) tv[j].tag = TW'(j);
        for (int i = 0; i < N; i++) begin
            tv[0].ops[i*W +: W] = 48'hFFFF_FFFF_FFFF;
            tv[1].ops[i*W +: W] = W'(i + 1);
            tv[2].ops[i*W +: W] = '0;
            tv[3].ops[i*W +: W] = (i == 0) ? 48'hFFFF_FFFF_FFFF : 48'h0;
            tv[4].ops[i*W +: W] = 48'h1 << (4 * i);
            tv[5].ops[i*W +: W] = 48'h8000_0000_0000;
            tv[6].ops[i*W +: W] = (i % 2 == 1) ? 48'h5555_5555_5555 : 48'hAAAA_AAAA_AAAA;
        end
        tv[0].exp = 52'hB_FFFF_FFFF_FFF4;
        tv[1].exp = 52'd78;
        tv[2].exp = 52'd0;
        tv[3].exp = 52'h0_FFFF_FFFF_FFFF;
        tv[4].exp = 52'h0_1111_1111_1111;
        tv[5].exp = 52'h6_0000_0000_0000;
        tv[6].exp = 52'h5_FFFF_FFFF_FFFA;

        #12;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_sum", 64'(out_sum), 64'd0);
        chk("rst_carry", 64'(out_carry), 64'd0);
        chk("rst_tag", 64'(out_tag), 64'd0);
`ifdef CSA_FINAL_ADD_EN
        chk("rst_total", 64'(out_total), 64'd0);
`endif
        @(posedge clk);
        #1 rst = 0;
        @(posedge clk);
        #1 chk("post_rst_in_ready", 64'(in_ready), 64'd1);
        chk("post_rst_out_valid", 64'(out_valid), 64'd0);

        for (int j = 0; j < 7; j++) run_vec(tv[j].ops, tv[j].tag, tv[j].exp, $sformatf("vec%0d", j));

        qclear();
        for (int j = 0; j < 12; j++) begin
            in_valid = 1;
            in_tag   = TW'(j);
            in_ops   = tv[1].ops;
            @(negedge clk);
            chk($sformatf("stream_ready%0d", j), 64'(in_ready), 64'd1);
            @(posedge clk);
            #1;
        end
        in_valid = 0;
        n = 0;
        while (q_sum.size() < 12 && n < 40) begin
            @(posedge clk);
            #1 n++;
        end
        chk("stream_count", 64'(q_sum.size()), 64'd12);
        for (int j = 0; j < q_sum.size() && j < 12; j++) begin
            chk($sformatf("stream_sum%0d", j), 64'(q_sum[j]), 64'd78);
            chk($sformatf("stream_tag%0d", j), 64'(q_tag[j]), 64'(j));
            chk($sformatf("stream_cyc%0d", j), 64'(q_cyc[j] - q_cyc[0]), 64'(j));
        end

        qclear();
        out_ready = 0;
        k  = 0;
        s7 = '0;
        for (int c = 0; c < 10; c++) begin
            in_valid = 1;
            in_tag   = TW'(k);
            in_ops   = all_ops(W'(k + 1));
            @(negedge clk);
            a = int'(in_ready);
            if (c == 7) s7 = out_sum;
            @(posedge clk);
            #1 if (a != 0) k++;
        end
        chk("stall_accepts", 64'(k), 64'(FULL));
        chk("stall_in_ready", 64'(in_ready), 64'd0);
        chk("stall_out_valid", 64'(out_valid), 64'd1);
        chk("stall_tag", 64'(out_tag), 64'd0);
        chk("stall_sum_hold", 64'(out_sum), 64'(s7));
        chk("stall_res", 64'(res), 64'd12);
        out_ready = 1;
        n = 0;
        while (k < 10 && n < 40) begin
            in_valid = 1;
            in_tag   = TW'(k);
            in_ops   = all_ops(W'(k + 1));
            @(negedge clk);
            a = int'(in_ready);
            @(posedge clk);
            #1 if (a != 0) k++;
            n++;
        end
        in_valid = 0;
        n = 0;
        while (q_sum.size() < 10 && n < 40) begin
            @(posedge clk);
            #1 n++;
        end
        repeat (3) @(posedge clk);
        #1 chk("drain_count", 64'(q_sum.size()), 64'd10);
        for (int j = 0; j < q_sum.size() && j < 10; j++) begin
            chk($sformatf("drain_tag%0d", j), 64'(q_tag[j]), 64'(j));
            chk($sformatf("drain_sum%0d", j), 64'(q_sum[j]), 64'(12 * (j + 1)));
        end

        qclear();
        for (int j = 0; j < 3; j++) begin
            in_valid = 1;
            in_tag   = TW'(j + 1);
            in_ops   = all_ops(W'(j + 1));
            @(posedge clk);
            #1;
        end
        in_valid = 0;
        rst = 1;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        chk("midrst_sum", 64'(out_sum), 64'd0);
        @(posedge clk);
        #1 rst = 0;
        repeat (10) @(posedge clk);
        #1 chk("midrst_no_partial", 64'(q_sum.size()), 64'd0);
        run_vec(tv[0].ops, 4'd9, tv[0].exp, "post_midrst");

        in_ops2   = {3{8'hFF}};
        in_valid2 = 1;
        @(negedge clk);
        chk("small_in_ready", 64'(in_ready2), 64'd1);
        @(posedge clk);
        #1 in_valid2 = 0;
        n = 0;
        while (!out_valid2 && n < 20) begin
            @(posedge clk);
            #1 n++;
        end
        chk("small_latency", 64'(n), 64'(LAT2));
        chk("small_sum", 64'(res2), 64'h2FD);
        chk("small_carry_b0", 64'(out_carry2[0]), 64'd0);
`ifdef CSA_FINAL_ADD_EN
        chk("small_total", 64'(out_total2), 64'h2FD);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
